// File: rtl/register_file_bist.sv
// March-style BIST for a DEPTH x WIDTH multi-port register file: LFSR data, write then read back on each port.
// Optional feature macro: RF_BIST_STOP_ON_FAIL_EN (end the run at the first mismatching compare).
module register_file_bist #(
    parameter int          DEPTH  = 64,
    parameter int          WIDTH  = 32,
    parameter int          PASSES = 32,
    parameter logic [31:0] SEED   = 32'hACE1_0001
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [$clog2(DEPTH)-1:0] fail_addr,
    output logic [1:0]               fail_port,
    output logic [15:0]              err_count,
    output logic                     write_en,
    output logic [$clog2(DEPTH)-1:0] waddr,
    output logic [WIDTH-1:0]         wdata,
    output logic [1:0]               read_en,
    output logic [$clog2(DEPTH)-1:0] raddr_0,
    output logic [$clog2(DEPTH)-1:0] raddr_1,
    input  logic [WIDTH-1:0]         rdata_0,
    input  logic [WIDTH-1:0]         rdata_1
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              PW        = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [31:0]     LFSR_MASK = 32'h8020_0003;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW-1:0]   LAST_PASS = PW'(PASSES - 1);
`ifdef RF_BIST_STOP_ON_FAIL_EN
    localparam logic            STOP_ON_FAIL = 1'b1;
`else
    localparam logic            STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_RD0   = 3'd2,
        S_RD1   = 3'd3,
        S_RDB   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Galois right-shift step, x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] value);
        if (value[0]) begin
            lfsr_step = {1'b0, value[31:1]} ^ LFSR_MASK;
        end else begin
            lfsr_step = {1'b0, value[31:1]};
        end
    endfunction

    state_t            state_r, next_state_s;
    logic [AW-1:0]     addr_r, next_addr_s;
    logic [PW-1:0]     pass_r, next_pass_s;
    logic [31:0]       lfsr_r, next_lfsr_s;
    logic [WIDTH-1:0]  exp_r;
    logic [1:0]        mm_s;
    logic              hit_s;
    logic              stop_s;

    // Per-port mismatch for the port(s) active in the current read phase
    always_comb begin
        mm_s = 2'b00;
        case (state_r)
            S_RD0:   mm_s = {1'b0, (rdata_0 != exp_r)};
            S_RD1:   mm_s = {(rdata_1 != exp_r), 1'b0};
            S_RDB:   mm_s = {(rdata_1 != exp_r), (rdata_0 != exp_r)};
            default: mm_s = 2'b00;
        endcase
    end

    assign hit_s  = |mm_s;
    assign stop_s = STOP_ON_FAIL & hit_s & ~fail;

    // Next-state, address/pass sequencing and LFSR advance
    always_comb begin
        next_state_s = state_r;
        next_addr_s  = addr_r;
        next_pass_s  = pass_r;
        next_lfsr_s  = lfsr_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_WRITE;
                    next_addr_s  = {AW{1'b0}};
                    next_pass_s  = {PW{1'b0}};
                    next_lfsr_s  = SEED;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_WRITE: begin
                next_state_s = S_RD0;
                next_lfsr_s  = lfsr_step(lfsr_r);
            end
            S_RD0:   next_state_s = stop_s ? S_DONE : S_RD1;
            S_RD1:   next_state_s = stop_s ? S_DONE : S_RDB;
            S_RDB: begin
                if (stop_s) begin
                    next_state_s = S_DONE;
                end else if (pass_r != LAST_PASS) begin
                    next_state_s = S_WRITE;
                    next_pass_s  = pass_r + PW'(1);
                end else if (addr_r != LAST_ADDR) begin
                    next_state_s = S_WRITE;
                    next_pass_s  = {PW{1'b0}};
                    next_addr_s  = addr_r + AW'(1);
                end else begin
                    next_state_s = S_DONE;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Control state, counters, LFSR and expected-data latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            addr_r  <= {AW{1'b0}};
            pass_r  <= {PW{1'b0}};
            lfsr_r  <= SEED;
            exp_r   <= {WIDTH{1'b0}};
        end else begin
            state_r <= next_state_s;
            addr_r  <= next_addr_s;
            pass_r  <= next_pass_s;
            lfsr_r  <= next_lfsr_s;
            if (state_r == S_WRITE) begin
                exp_r <= WIDTH'(lfsr_r);
            end else begin
                exp_r <= exp_r;
            end
        end
    end

    // RF-side outputs, registered from the next state so they line up with that state's cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            write_en <= 1'b0;
            waddr    <= {AW{1'b0}};
            wdata    <= {WIDTH{1'b0}};
            read_en  <= 2'b00;
            raddr_0  <= {AW{1'b0}};
            raddr_1  <= {AW{1'b0}};
        end else begin
            busy     <= (next_state_s == S_WRITE) || (next_state_s == S_RD0) ||
                        (next_state_s == S_RD1)   || (next_state_s == S_RDB);
            done     <= (next_state_s == S_DONE);
            write_en <= (next_state_s == S_WRITE);
            if (next_state_s == S_WRITE) begin
                waddr <= next_addr_s;
                wdata <= WIDTH'(next_lfsr_s);
            end
            case (next_state_s)
                S_RD0:   read_en <= 2'b01;
                S_RD1:   read_en <= 2'b10;
                S_RDB:   read_en <= 2'b11;
                default: read_en <= 2'b00;
            endcase
            if ((next_state_s == S_RD0) || (next_state_s == S_RDB)) begin
                raddr_0 <= next_addr_s;
            end
            if ((next_state_s == S_RD1) || (next_state_s == S_RDB)) begin
                raddr_1 <= next_addr_s;
            end
        end
    end

    // Result capture: sticky first failure plus saturating count of failing compare cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail      <= 1'b0;
            fail_addr <= {AW{1'b0}};
            fail_port <= 2'b00;
            err_count <= 16'h0000;
        end else if ((state_r == S_IDLE) && start) begin
            fail      <= 1'b0;
            fail_addr <= {AW{1'b0}};
            fail_port <= 2'b00;
            err_count <= 16'h0000;
        end else if (hit_s) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'h0001;
            end
            if (!fail) begin
                fail      <= 1'b1;
                fail_addr <= addr_r;
                fail_port <= mm_s;
            end
        end
    end

endmodule
